// File: rtl/cpu_pkg.sv
// Shared CPU definitions: the memory arbiter state encoding and port owner codes.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

endpackage

// File: rtl/arb_pick2.sv
// Two-requester winner select (CPU vs DMA).
// Build option MEM_ARB_RR_EN: when defined, contention is resolved round-robin
// against last_owner; otherwise the CPU always wins.
module arb_pick2
  import cpu_pkg::*;
(
  input  logic cpu_req,
  input  logic dma_req,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_owner
);

  assign grant_valid = cpu_req | dma_req;

`ifdef MEM_ARB_RR_EN
  // On contention the side that did not own the previous transaction wins.
  always_comb begin
    grant_owner = OWNER_CPU;
    if (cpu_req && dma_req) begin
      grant_owner = ~last_owner;
    end else if (dma_req) begin
      grant_owner = OWNER_DMA;
    end
  end
`else
  // Fixed priority: the DMA only wins when the CPU is not asking.
  assign grant_owner = (dma_req && !cpu_req) ? OWNER_DMA : OWNER_CPU;

  // History is irrelevant under fixed priority.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between the CPU datapath and the DMA/loader port.
// IDLE -> ACCESS (MEM_LAT cycles) -> DONE (one-cycle done pulse) -> IDLE.
// Build option MEM_ARB_RR_EN selects round-robin contention handling
// (see arb_pick2); without it the CPU has fixed priority.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  arb_state_t state;
  logic [3:0] lat_cnt;
  logic       last_owner;
  logic       grant_valid;
  logic       grant_owner;

  arb_pick2 u_pick (
    .cpu_req     (cpu_req),
    .dma_req     (dma_req),
    .last_owner  (last_owner),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

`ifdef MEM_ARB_RR_EN
  // Remember who won the latest grant; reset favours the CPU on first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= OWNER_DMA;
    end else if (state == IDLE && grant_valid) begin
      last_owner <= grant_owner;
    end
  end
`else
  assign last_owner = OWNER_DMA;
`endif

  // The CPU sequence counter holds while its access is outstanding.
  assign cpu_stall = cpu_req & ~cpu_done;
  assign busy      = (state != IDLE);

  // Arbitration FSM. mem_we/mem_addr/mem_wdata double as the payload latch, so
  // the memory never sees the live requester inputs after the grant edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat_cnt   <= 4'd0;
      owner     <= OWNER_CPU;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_done  <= 1'b0;
      dma_done  <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            state   <= ACCESS;
            owner   <= grant_owner;
            lat_cnt <= LAT_LOAD;
            mem_en  <= 1'b1;
            if (grant_owner == OWNER_DMA) begin
              mem_we    <= dma_we;
              mem_addr  <= dma_addr;
              mem_wdata <= dma_wdata;
            end else begin
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
            end
          end
        end
        ACCESS: begin
          if (lat_cnt == 4'd0) begin
            state    <= DONE;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            cpu_done <= (owner == OWNER_CPU);
            dma_done <= (owner == OWNER_DMA);
            if (!mem_we) begin
              if (owner == OWNER_DMA) begin
                dma_rdata <= mem_rdata;
              end else begin
                cpu_rdata <= mem_rdata;
              end
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        DONE: begin
          state    <= IDLE;
          cpu_done <= 1'b0;
          dma_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
